bcp_assign_unit: RTL and testbench
==================================

// Module: bcp_assign_unit
// PURPOSE
//  Consumer side of the BCP implication interface: accepts implications (var mask + polarity) from check units,
//  buffers them in a small FIFO, applies them one per cycle to the live assignment/free vectors, detects conflicts.
//  Drives the assignment/free buses the check units read; signals round completion to the solver controller.
// PARAMETERS
//  VAR_NUM     8  number of variables (width of mask/value/assignment/free)
//  FIFO_DEPTH  4  implication buffer entries (power of 2, >=2); AW=$clog2(FIFO_DEPTH)
// PORTS
//  clock           in   1        clock, rising edge
//  reset           in   1        reset, asynchronous, active-high
//  start           in   1        pulse: load init vectors, flush FIFO, enter RUN
//  init_assignment in   VAR_NUM  assignment loaded on start
//  init_free       in   VAR_NUM  free mask loaded on start (1 = unassigned)
//  round_end       in   1        pulse: check units have finished issuing for this round
//  imp_valid       in   1        implication offered
//  imp_ready       out  1        implication accepted when imp_valid&&imp_ready at clock edge
//  imp_mask        in   VAR_NUM  vars implied (normally one-hot; multi-hot applied bitwise)
//  imp_value       in   VAR_NUM  polarity per var (bit used only where imp_mask=1)
//  assignment      out  VAR_NUM  current values
//  free            out  VAR_NUM  current unassigned mask
//  assign_update   out  1        1-cycle pulse: assignment/free changed last edge
//  busy            out  1        state==RUN
//  done            out  1        state==DONE (level)
//  conflict        out  1        state==CONFLICT (level)
//  conflict_var    out  VAR_NUM  vars that conflicted (held in CONFLICT)
// BEHAVIOUR
//  Reset: assignment=0, free=all 1s, FIFO empty, state IDLE, imp_ready=0, assign_update=0, busy=0, done=0,
//   conflict=0, conflict_var=0, pending_end=0. Reset mid-operation discards FIFO contents and pending round_end.
//  FSM IDLE/RUN/DONE/CONFLICT. start in any state (highest priority): assignment<=init_assignment,
//   free<=init_free, FIFO flushed, conflict_var<=0, pending_end<=0, ->RUN; a push that cycle is dropped.
//  imp_ready = (state==RUN) && !fifo_full; no same-cycle pass-through, so full+pop still deasserts ready.
//  RUN, FIFO non-empty: pop head (m,v) each cycle. hit = m & ~free & (assignment ^ v).
//   hit!=0: no update, conflict_var<=hit, FIFO flushed, ->CONFLICT.
//   else: assignment<=(assignment&~m)|(v&m), free<=free&~m; assign_update=1 next cycle iff (m&free)!=0.
//   Redundant (same-polarity, already assigned) and all-zero masks are consumed silently.
//  Latency: implication accepted at edge N is applied at edge N+1 at the earliest (N+k if k entries ahead).
//  Simultaneous push+pop: both take effect; count unchanged; pointers wrap mod FIFO_DEPTH.
//  round_end in RUN: pending_end<=1. RUN->DONE when pending_end (or round_end now) && FIFO empty && no push.
//  DONE/CONFLICT: imp_ready=0, vectors hold; leave only via start or reset. round_end outside RUN ignored.
// CONFIGURATION
//  BCP_IMPL_COUNT_EN defined: extra output impl_count [15:0]; +1 per pop that clears >=1 free bit,
//   saturates at 16'hFFFF, cleared by reset and start. Undefined: port and counter absent; rest identical.
// STRUCTURE
//  Shared package bcp_pkg: state encoding (IDLE,RUN,DONE,CONFLICT), VAR_NUM default, implication
//   entry layout {mask,value} (2*VAR_NUM, mask in upper half as in clause registers).
//  Sub-module bcp_impl_fifo: synchronous FIFO, WIDTH=2*VAR_NUM, DEPTH=FIFO_DEPTH, push/pop/flush,
//   full/empty, async reset. Top holds FSM, apply/conflict logic, optional counter.
// TESTING
//  1 start, init_free=FF, init_assignment=00; push mask=04,value=04 -> next edge assignment=04, free=FB, assign_update pulse.
//  2 after 1, push mask=04,value=00 -> CONFLICT, conflict_var=04, assignment=04 held, imp_ready=0.
//  3 stall round_end handling: push 5 entries back-to-back with FIFO_DEPTH=4 -> ready drops at count 4, no loss,
//    all applied in order; round_end mid-stream -> done only after last pop.
//  4 redundant mask=04,value=04 after 1 -> no change, no assign_update, (impl_count unchanged with BCP_IMPL_COUNT_EN).
//  5 reset asserted with 3 entries queued -> all outputs at reset values, FIFO empty; start then re-run clean.
//  6 start while in CONFLICT with init_free=0F -> RUN, free=0F, conflict=0, conflict_var=0.

Source files
------------

// File: rtl/bcp_pkg.sv
// Shared definitions for the BCP assign unit: FSM state encoding, default sizes,
// and implication entry layout ({mask, value}, mask in the upper half).
package bcp_pkg;

   localparam int unsigned BCP_VAR_NUM    = 8;
   localparam logic [15:0] IMPL_COUNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      DONE     = 2'd2,
      CONFLICT = 2'd3
   } bcp_state_t;

endpackage

// File: rtl/bcp_impl_fifo.sv
// Implication buffer: synchronous FIFO with push/pop/flush, full/empty flags and
// asynchronous active-high reset. Flush wins over push and pop in the same cycle.
module bcp_impl_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/bcp_assign_unit.sv
// BCP implication consumer: buffers implications, applies one per cycle to the
// assignment/free vectors and detects conflicts. Optional macro: BCP_IMPL_COUNT_EN.
module bcp_assign_unit
   import bcp_pkg::*;
#(
   parameter int unsigned VAR_NUM    = BCP_VAR_NUM,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [VAR_NUM-1:0] init_assignment,
   input  logic [VAR_NUM-1:0] init_free,
   input  logic               round_end,
   input  logic               imp_valid,
   output logic               imp_ready,
   input  logic [VAR_NUM-1:0] imp_mask,
   input  logic [VAR_NUM-1:0] imp_value,
   output logic [VAR_NUM-1:0] assignment,
   output logic [VAR_NUM-1:0] free,
   output logic               assign_update,
   output logic               busy,
   output logic               done,
   output logic               conflict,
   output logic [VAR_NUM-1:0] conflict_var
`ifdef BCP_IMPL_COUNT_EN
   ,
   output logic [15:0]        impl_count
`endif
);

   bcp_state_t           state;
   bcp_state_t           next_state;
   logic                 pending_end;
   logic                 push;
   logic                 pop;
   logic                 flush;
   logic                 full;
   logic                 empty;
   logic [2*VAR_NUM-1:0] head;
   logic [VAR_NUM-1:0]   head_mask;
   logic [VAR_NUM-1:0]   head_value;
   logic [VAR_NUM-1:0]   hit;
   logic [VAR_NUM-1:0]   newly_set;
   logic                 conflict_now;

   assign {head_mask, head_value} = head;
   assign hit          = head_mask & ~free & (assignment ^ head_value);
   assign newly_set    = head_mask & free;
   assign pop          = (state == RUN) && !empty && !start;
   assign conflict_now = pop && (hit != '0);
   assign push         = imp_valid && imp_ready && !start;
   assign flush        = start || conflict_now;

   bcp_impl_fifo #(
      .WIDTH (2*VAR_NUM),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data ({imp_mask, imp_value}),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (start) begin
         next_state = RUN;
      end else if (state == RUN) begin
         if (conflict_now)
            next_state = CONFLICT;
         else if ((pending_end || round_end) && empty && !push)
            next_state = DONE;
      end
   end

   always_comb begin
      imp_ready = (state == RUN) && !full;
      busy      = (state == RUN);
      done      = (state == DONE);
      conflict  = (state == CONFLICT);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         assignment    <= '0;
         free          <= '1;
         conflict_var  <= '0;
         pending_end   <= 1'b0;
         assign_update <= 1'b0;
      end else if (start) begin
         assignment    <= init_assignment;
         free          <= init_free;
         conflict_var  <= '0;
         pending_end   <= 1'b0;
         assign_update <= 1'b0;
      end else begin
         assign_update <= 1'b0;
         if ((state == RUN) && round_end) pending_end <= 1'b1;
         if (pop) begin
            if (hit != '0) begin
               conflict_var <= hit;
            end else begin
               assignment    <= (assignment & ~head_mask) | (head_value & head_mask);
               free          <= free & ~head_mask;
               assign_update <= (newly_set != '0);
            end
         end
      end
   end

`ifdef BCP_IMPL_COUNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         impl_count <= '0;
      else if (start)
         impl_count <= '0;
      else if (pop && (hit == '0) && (newly_set != '0) && (impl_count != IMPL_COUNT_MAX))
         impl_count <= impl_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_bcp_assign_unit.sv
// Self-checking bench for bcp_assign_unit: queue-based reference model compared on
// every falling edge, directed scenarios with literal expectations, then random traffic.
module tb_bcp_assign_unit;

   localparam int unsigned VN = 8;
   localparam int unsigned FD = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [VN-1:0] init_assignment = '0;
   logic [VN-1:0] init_free = '0;
   logic          round_end = 1'b0;
   logic          imp_valid = 1'b0;
   logic          imp_ready;
   logic [VN-1:0] imp_mask = '0;
   logic [VN-1:0] imp_value = '0;
   logic [VN-1:0] assignment;
   logic [VN-1:0] free;
   logic          assign_update;
   logic          busy;
   logic          done;
   logic          conflict;
   logic [VN-1:0] conflict_var;
`ifdef BCP_IMPL_COUNT_EN
   logic [15:0]   impl_count;
`endif

   int checks = 0;
   int errors = 0;

   bcp_assign_unit #(
      .VAR_NUM    (VN),
      .FIFO_DEPTH (FD)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .init_assignment (init_assignment),
      .init_free       (init_free),
      .round_end       (round_end),
      .imp_valid       (imp_valid),
      .imp_ready       (imp_ready),
      .imp_mask        (imp_mask),
      .imp_value       (imp_value),
      .assignment      (assignment),
      .free            (free),
      .assign_update   (assign_update),
      .busy            (busy),
      .done            (done),
      .conflict        (conflict),
      .conflict_var    (conflict_var)
`ifdef BCP_IMPL_COUNT_EN
      ,
      .impl_count      (impl_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 run, 2 done, 3 conflict
   int        m_mode = 0;
   bit [7:0]  m_asg = 8'h00;
   bit [7:0]  m_free = 8'hFF;
   bit [7:0]  m_cvar = 8'h00;
   bit        m_upd = 1'b0;
   bit        m_pend = 1'b0;
   bit [15:0] m_cnt = 16'h0;
   bit [7:0]  q_mask[$];
   bit [7:0]  q_val[$];

   always @(posedge clock or posedge reset) begin
      int       mode0;
      bit       accepted;
      bit       was_empty;
      bit [7:0] hm, hv, hit;
      if (reset) begin
         m_mode = 0; m_asg = 8'h00; m_free = 8'hFF; m_cvar = 8'h00;
         m_upd = 0; m_pend = 0; m_cnt = 0;
         q_mask.delete(); q_val.delete();
      end else if (start) begin
         m_mode = 1; m_asg = init_assignment; m_free = init_free; m_cvar = 8'h00;
         m_upd = 0; m_pend = 0; m_cnt = 0;
         q_mask.delete(); q_val.delete();
      end else begin
         mode0     = m_mode;
         accepted  = imp_valid && (mode0 == 1) && (q_mask.size() < FD);
         was_empty = (q_mask.size() == 0);
         m_upd     = 0;
         if (mode0 == 1) begin
            if (!was_empty) begin
               hm  = q_mask.pop_front();
               hv  = q_val.pop_front();
               hit = hm & ~m_free & (m_asg ^ hv);
               if (hit != 0) begin
                  m_cvar = hit;
                  m_mode = 3;
                  accepted = 0;
                  q_mask.delete(); q_val.delete();
               end else begin
                  m_upd = ((hm & m_free) != 0);
                  if (m_upd && m_cnt != 16'hFFFF) m_cnt++;
                  m_asg  = (m_asg & ~hm) | (hv & hm);
                  m_free = m_free & ~hm;
               end
            end
            if (m_mode == 1 && (m_pend || round_end) && was_empty && !accepted) m_mode = 2;
            if (round_end) m_pend = 1;
         end
         if (accepted) begin
            q_mask.push_back(imp_mask);
            q_val.push_back(imp_value);
         end
      end
   end

   always @(negedge clock) begin
      check("imp_ready", imp_ready, (m_mode == 1) && (q_mask.size() < FD));
      check("assignment", assignment, m_asg);
      check("free", free, m_free);
      check("assign_update", assign_update, m_upd);
      check("busy", busy, m_mode == 1);
      check("done", done, m_mode == 2);
      check("conflict", conflict, m_mode == 3);
      check("conflict_var", conflict_var, m_cvar);
`ifdef BCP_IMPL_COUNT_EN
      check("impl_count", impl_count, m_cnt);
`endif
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input logic [7:0] a, input logic [7:0] f);
      start = 1; init_assignment = a; init_free = f;
      cyc();
      start = 0;
   endtask

   task automatic push(input logic [7:0] m, input logic [7:0] v);
      imp_valid = 1; imp_mask = m; imp_value = v;
      cyc();
      imp_valid = 0;
   endtask

   task automatic check_reset_vals();
      check("rst_assignment", assignment, 8'h00);
      check("rst_free", free, 8'hFF);
      check("rst_ready", imp_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_conflict", conflict, 0);
      check("rst_cvar", conflict_var, 8'h00);
      check("rst_update", assign_update, 0);
   endtask

   initial begin
      int n;
      #1 reset = 1;
      repeat (2) @(posedge clock);
      #1 reset = 0;
      @(negedge clock);
      check_reset_vals();

      // Single implication applied one edge after acceptance
      do_start(8'h00, 8'hFF);
      push(8'h04, 8'h04);
      cyc();
      @(negedge clock);
      check("t1_assignment", assignment, 8'h04);
      check("t1_free", free, 8'hFB);
      check("t1_update", assign_update, 1);

      // Redundant implication consumed silently
      push(8'h04, 8'h04);
      cyc();
      @(negedge clock);
      check("t4_assignment", assignment, 8'h04);
      check("t4_free", free, 8'hFB);
      check("t4_update", assign_update, 0);

      // Opposite polarity on an assigned var conflicts
      push(8'h04, 8'h00);
      cyc();
      @(negedge clock);
      check("t2_conflict", conflict, 1);
      check("t2_cvar", conflict_var, 8'h04);
      check("t2_assignment", assignment, 8'h04);
      check("t2_ready", imp_ready, 0);

      // Restart out of CONFLICT
      do_start(8'hA5, 8'h0F);
      @(negedge clock);
      check("t6_free", free, 8'h0F);
      check("t6_assignment", assignment, 8'hA5);
      check("t6_conflict", conflict, 0);
      check("t6_cvar", conflict_var, 8'h00);
      check("t6_busy", busy, 1);

      // Back-to-back stream with round_end mid-stream
      cyc();
      do_start(8'h00, 8'hFF);
      for (int k = 0; k < 5; k++) begin
         imp_valid = 1; imp_mask = 8'(1 << k); imp_value = 8'h15;
         n = 0;
         while (!imp_ready && n < 20) begin cyc(); n++; end
         if (n == 20) check("t3_ready_timeout", 0, 1);
         round_end = (k == 2);
         cyc();
         round_end = 0;
      end
      imp_valid = 0;
      n = 0;
      while (!done && n < 20) begin cyc(); n++; end
      check("t3_done_timeout", done, 1);
      @(negedge clock);
      check("t3_assignment", assignment, 8'h15);
      check("t3_free", free, 8'hE0);

      // Reset mid-stream discards everything
      cyc();
      do_start(8'h00, 8'hFF);
      imp_valid = 1; imp_mask = 8'h01; imp_value = 8'h01;
      cyc();
      imp_mask = 8'h02;
      cyc();
      reset = 1;
      @(negedge clock);
      check_reset_vals();
      cyc();
      reset = 0; imp_valid = 0;
      do_start(8'h00, 8'hFF);
      push(8'h01, 8'h01);
      cyc();
      @(negedge clock);
      check("t5_assignment", assignment, 8'h01);
      check("t5_free", free, 8'hFE);

      // Random traffic against the model
      cyc();
      for (int i = 0; i < 3000; i++) begin
         reset           = ($urandom % 300 == 0);
         start           = ($urandom % 40 == 0);
         init_assignment = 8'($urandom);
         init_free       = 8'($urandom);
         round_end       = ($urandom % 15 == 0);
         imp_valid       = $urandom % 2;
         case ($urandom % 8)
            0:       imp_mask = 8'h00;
            1:       imp_mask = 8'($urandom);
            default: imp_mask = 8'(1 << ($urandom % 8));
         endcase
         imp_value = 8'($urandom);
         cyc();
      end
      reset = 0; start = 0; imp_valid = 0; round_end = 0;
      cyc();
      @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
